fpu_add_arbiter: RTL and testbench
==================================

// Module: fpu_add_arbiter
// PURPOSE
//  Shares one pipelined fpu_top add/sub datapath among N requesters (VALU lanes/issue slots).
//  Picks one requester per cycle (round-robin) and registers its operands into the FPU.
//  Tracks each in-flight op's requester id through a tag pipe matched to the FPU latency.
//  Returns the result and exception flags to the originating requester.
// PARAMETERS
//  N        4   number of requesters (2..8)
//  W        32  operand width, passed to fpu_top
//  FPU_LAT  1   cycles from fpu_valid sampled to fpu_result/fpu_exc valid (>=1)
//  IDW      $clog2(N)  requester id width (derived, localparam)
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active-high
//  en          in   1        1 = grants allowed; 0 = hold off new grants, in-flight ops drain
//  req_valid   in   N        request k present
//  req_ready   out  N        one-hot grant; handshake for k = req_valid[k] & req_ready[k]
//  req_mode    in   3*N      rounding mode, slice [3k+2:3k] for requester k
//  req_op      in   2*N      [0] add, [1] sub; slice [2k+1:2k]
//  req_a       in   W*N      operand A, slice [W*k+W-1:W*k]
//  req_b       in   W*N      operand B, same slicing
//  fpu_valid   out  1        to fpu_top i_valid
//  fpu_mode    out  3        to fpu_top i_mode
//  fpu_op      out  2        to fpu_top i_operation
//  fpu_a       out  W        to fpu_top i_inputA
//  fpu_b       out  W        to fpu_top i_inputB
//  fpu_result  in   W        from fpu_top o_output
//  fpu_exc     in   5        from fpu_top o_exeption
//  rsp_valid   out  N        one-hot: response for requester k this cycle
//  rsp_id      out  IDW      id of responding requester
//  rsp_result  out  W        result
//  rsp_exc     out  5        exception flags, passed through unchanged
//  busy        out  1        1 while any op is in the issue reg or tag pipe
//  issue_cnt   out  16       total grants since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: fpu_valid=0, fpu_mode/op/a/b=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_exc=0,
//   busy=0, issue_cnt=0, tag pipe all invalid, rr pointer=N-1 (requester 0 wins first).
//  Arbitration (combinational): if en=0, req_ready=0. Otherwise search from ptr+1 upward,
//   wrapping mod N; the first k with req_valid[k]=1 gets req_ready[k]=1. Max one grant/cycle.
//  req_ready never depends on req_ready feedback. Requester holds req_* stable until handshake.
//  Handshake in cycle T: ptr<=k; issue_cnt<=issue_cnt+1.
//   fpu_valid/mode/op/a/b <= requester k's fields; tag stage0 <= {1,k}.
//   No handshake in T: fpu_valid<=0; operand regs hold; tag stage0 <= invalid.
//  FPU side: fpu_valid high in T+1. Tag pipe has FPU_LAT stages, shifting every cycle.
//   Its tail aligns with fpu_result/fpu_exc in cycle T+1+FPU_LAT.
//  Response: when the tail is valid, register rsp_valid<=onehot(id), rsp_id<=id,
//   rsp_result<=fpu_result, rsp_exc<=fpu_exc. Otherwise rsp_valid<=0 and the data regs hold.
//  End-to-end: handshake in T -> rsp_valid in T+2+FPU_LAT (default T+3). Throughput is 1 op/clk.
//  Responses have no backpressure; requesters must accept rsp_valid whenever it is asserted.
//  Order: responses come back in grant order. A requester may have several ops in flight.
//  busy = fpu_valid | (any tag stage valid) | (any rsp_valid bit).
//  en falls while ops are in flight: no new grants; existing ops complete normally.
//  rst while ops are in flight: all in-flight ops are dropped, no rsp_valid in the following cycles.
//  Result data is not interpreted. NaN, inf and denormal handling belong to fpu_top.
// TESTING
//  1) Single op: req0 A=404ccccd B=40966666 op=add mode=0 at T.
//     Expect rsp_valid=0001, rsp_id=0, result 40fccccc, exc 01 at T+3 (FPU_LAT=1).
//  2) All 4 requesting continuously: grants go 0,1,2,3,0,... with one per cycle;
//     issue_cnt +1 per cycle; rsp ids come back in the same order.
//  3) Only req2 and req3 valid, ptr=2: next grant goes to req3, then req2, alternating;
//     no grant to an idle requester.
//  4) Back-to-back ops from req1: sub 40e9999a-40e99999 -> 35000000/00;
//     sub 7f800000-7f800000 -> 7fc00000/02 (compare bits [30:0] only). Both arrive on consecutive cycles.
//  5) en=0 with req_valid=1111: req_ready=0 and fpu_valid=0.
//     Earlier ops still respond and busy falls after the drain.
//  6) rst asserted one cycle after a grant: no rsp_valid follows.
//     After release, busy=0, issue_cnt=0 and req0 wins first.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// Round-robin front end sharing one pipelined FPU add/sub unit among N requesters.
// Grants are registered into the FPU, and a tag pipe routes each result back to its requester.
module fpu_add_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int FPU_LAT = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [N-1:0]                      req_valid,
  output logic [N-1:0]                      req_ready,
  input  logic [3*N-1:0]                    req_mode,
  input  logic [2*N-1:0]                    req_op,
  input  logic [W*N-1:0]                    req_a,
  input  logic [W*N-1:0]                    req_b,
  output logic                              fpu_valid,
  output logic [2:0]                        fpu_mode,
  output logic [1:0]                        fpu_op,
  output logic [W-1:0]                      fpu_a,
  output logic [W-1:0]                      fpu_b,
  input  logic [W-1:0]                      fpu_result,
  input  logic [4:0]                        fpu_exc,
  output logic [N-1:0]                      rsp_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] rsp_id,
  output logic [W-1:0]                      rsp_result,
  output logic [4:0]                        rsp_exc,
  output logic                              busy,
  output logic [15:0]                       issue_cnt
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           grant_any;
  logic [IDW-1:0] issue_id;
  logic [FPU_LAT-1:0] tag_valid;
  logic [IDW-1:0] tag_id [FPU_LAT];

  logic [W-1:0] a_arr    [N];
  logic [W-1:0] b_arr    [N];
  logic [2:0]   mode_arr [N];
  logic [1:0]   op_arr   [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign a_arr[k]    = req_a[W*k +: W];
    assign b_arr[k]    = req_b[W*k +: W];
    assign mode_arr[k] = req_mode[3*k +: 3];
    assign op_arr[k]   = req_op[2*k +: 2];
  end

  // Search starts just past the last winner so every requester gets a fair turn.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (en) begin
      for (int i = 1; i <= N; i++) begin
        cand = IDW'((int'(ptr) + i) % N);
        if (!grant_any && req_valid[cand]) begin
          req_ready[cand] = 1'b1;
          grant_id        = cand;
          grant_any       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= IDW'(N - 1);
      issue_cnt <= '0;
      fpu_valid <= 1'b0;
      fpu_mode  <= '0;
      fpu_op    <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      issue_id  <= '0;
    end else begin
      fpu_valid <= grant_any;
      if (grant_any) begin
        ptr       <= grant_id;
        issue_cnt <= issue_cnt + 16'd1;
        fpu_mode  <= mode_arr[grant_id];
        fpu_op    <= op_arr[grant_id];
        fpu_a     <= a_arr[grant_id];
        fpu_b     <= b_arr[grant_id];
        issue_id  <= grant_id;
      end
    end
  end

  // The issue register feeds the tag pipe, so the tail lines up with the FPU output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      for (int i = 0; i < FPU_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_valid[0] <= fpu_valid;
      tag_id[0]    <= issue_id;
      for (int i = 1; i < FPU_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_exc    <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_valid[FPU_LAT-1]) begin
        for (int k = 0; k < N; k++) rsp_valid[k] <= (tag_id[FPU_LAT-1] == IDW'(k));
        rsp_id     <= tag_id[FPU_LAT-1];
        rsp_result <= fpu_result;
        rsp_exc    <= fpu_exc;
      end
    end
  end

  assign busy = fpu_valid | (|tag_valid) | (|rsp_valid);

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Scoreboard bench for fpu_add_arbiter with a behavioural stand-in for fpu_top.
// A reference arbiter predicts each grant; expected responses are queued at handshake time.
module tb_fpu_add_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int FPU_LAT = 1;
  localparam int IDW     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [3*N-1:0]   req_mode;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic             fpu_valid;
  logic [2:0]       fpu_mode;
  logic [1:0]       fpu_op;
  logic [W-1:0]     fpu_a;
  logic [W-1:0]     fpu_b;
  logic [W-1:0]     fpu_result = '0;
  logic [4:0]       fpu_exc = '0;
  logic [N-1:0]     rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_result;
  logic [4:0]       rsp_exc;
  logic             busy;
  logic [15:0]      issue_cnt;

  logic [W-1:0] la    [N];
  logic [W-1:0] lb    [N];
  logic [1:0]   lop   [N];
  logic [2:0]   lmode [N];

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [4:0]  exc;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  int  checks  = 0;
  int  passes  = 0;
  int  cyc     = 0;
  int  mptr    = N - 1;
  int  exp_cnt = 0;

  fpu_add_arbiter #(.N(N), .W(W), .FPU_LAT(FPU_LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .fpu_valid(fpu_valid), .fpu_mode(fpu_mode), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .fpu_exc(fpu_exc),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_exc(rsp_exc),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign req_a[W*k +: W]    = la[k];
    assign req_b[W*k +: W]    = lb[k];
    assign req_op[2*k +: 2]   = lop[k];
    assign req_mode[3*k +: 3] = lmode[k];
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Known IEEE vectors return their real answers; anything else gets an operand hash.
  function automatic logic [36:0] fakeFpu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [2:0] mode);
    if (a == 32'h404ccccd && b == 32'h40966666 && op == 2'b01)
      return {5'h01, 32'h40fccccc};
    if (a == 32'h40e9999a && b == 32'h40e99999 && op == 2'b10)
      return {5'h00, 32'h35000000};
    if (a == 32'h7f800000 && b == 32'h7f800000 && op == 2'b10)
      return {5'h02, 32'h7fc00000};
    return {a[4:0] ^ b[9:5] ^ {mode, op}, a + {b[15:0], b[31:16]} + {27'd0, mode, op}};
  endfunction

  always @(posedge clk)
    if (fpu_valid) {fpu_exc, fpu_result} <= fakeFpu(fpu_a, fpu_b, fpu_op, fpu_mode);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference arbiter plus scoreboard, both sampled on the falling edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic [N-1:0] oh;
    logic [36:0]  r;
    int           g;
    sb_t          e;
    if (rst) begin
      sb.delete();
      mptr    = N - 1;
      exp_cnt = 0;
    end else begin
      exp_ready = '0;
      g = -1;
      if (en) begin
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (mptr + i) % N;
          if (g < 0 && req_valid[k]) g = k;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      checkOutput("req_ready", req_ready, exp_ready);
      if (g >= 0) begin
        r     = fakeFpu(la[g], lb[g], lop[g], lmode[g]);
        e.id  = g;
        e.res = r[31:0];
        e.exc = r[36:32];
        e.cyc = cyc;
        sb.push_back(e);
        mptr = g;
        exp_cnt++;
      end
    end
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", rsp_valid, 0);
      end else begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        checkOutput("rsp_valid", rsp_valid, oh);
        checkOutput("rsp_id", rsp_id, e.id);
        checkOutput("rsp_result", rsp_result, e.res);
        checkOutput("rsp_exc", rsp_exc, e.exc);
        checkOutput("rsp_latency", cyc - e.cyc, 2 + FPU_LAT);
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] v, input logic e);
    @(posedge clk);
    #1;
    req_valid = v;
    en        = e;
  endtask

  task automatic setLane(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [2:0] mode);
    la[k]    = a;
    lb[k]    = b;
    lop[k]   = op;
    lmode[k] = mode;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_drained"}, {62'd0, sb.size() != 0, busy}, 0);
    checkOutput({tag, "_issue_cnt"}, issue_cnt, exp_cnt[15:0]);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = '0;
    for (int k = 0; k < N; k++)
      setLane(k, $urandom, $urandom, 2'($urandom_range(1, 2)), 3'($urandom_range(0, 4)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_fpu_valid", fpu_valid, 0);
    checkOutput("rst_fpu_a", fpu_a, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_result", rsp_result, 0);
    checkOutput("rst_rsp_exc", rsp_exc, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_issue_cnt", issue_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    setLane(0, 32'h404ccccd, 32'h40966666, 2'b01, 3'd0);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    #4 checkOutput("t1_busy", busy, 1);
    waitDrain("t1");

    repeat (8) applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    waitDrain("t2");

    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b1100, 1'b1);
    #4 checkOutput("t3_first_grant", req_ready, 4'b1000);
    repeat (5) applyStimulus(4'b1100, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    waitDrain("t3");

    setLane(1, 32'h40e9999a, 32'h40e99999, 2'b10, 3'd0);
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b0010, 1'b1);
    setLane(1, 32'h7f800000, 32'h7f800000, 2'b10, 3'd0);
    applyStimulus(4'b0000, 1'b1);
    waitDrain("t4");

    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b1111, 1'b0);
    #4 checkOutput("t5_busy_inflight", busy, 1);
    repeat (4) begin
      applyStimulus(4'b1111, 1'b0);
      #4 checkOutput("t5_fpu_valid", fpu_valid, 0);
    end
    waitDrain("t5");
    applyStimulus(4'b0000, 1'b1);

    applyStimulus(4'b0001, 1'b1);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_issue_cnt", issue_cnt, 0);
    applyStimulus(4'b1111, 1'b1);
    #4 checkOutput("t6_first_grant", req_ready, 4'b0001);
    applyStimulus(4'b0000, 1'b1);
    waitDrain("t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule
